// File: rtl/lbist_pkg.sv
// Shared types and constants for the LBIST run-time sequencer.
//   lbist_state_e  : sequencer state encoding
//   lbist_ctrl_t   : bundle of the registered single-bit control outputs
//   LBIST_SEEDS    : LFSR seed table, one entry per seed
//   LBIST_MISR_GOLD: default golden signature
package lbist_pkg;

    localparam int unsigned LBIST_SEED_NUM   = 10;
    localparam int unsigned LBIST_SEED_WIDTH = 25;
    localparam int unsigned LBIST_MISR_SIZE  = 16;

    // 26815 decimal
    localparam logic [LBIST_MISR_SIZE-1:0] LBIST_MISR_GOLD = 16'h68BF;

    // Non-zero seeds so the LFSR never locks up in the all-zero state.
    localparam logic [LBIST_SEED_WIDTH-1:0] LBIST_SEEDS [LBIST_SEED_NUM] = '{
        25'h1A2B3C5, 25'h0F0E1D3, 25'h1234567, 25'h0ACE135, 25'h1BEEF01,
        25'h0C0FFEE, 25'h15A5A5A, 25'h0DEAD11, 25'h1F00F0F, 25'h0777777
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_LOAD,
        ST_SHIFT,
        ST_CAPTURE,
        ST_UNLOAD,
        ST_COMPARE,
        ST_DONE
    } lbist_state_e;

    typedef struct packed {
        logic lfsr_load;
        logic lfsr_en;
        logic misr_en;
        logic misr_clr;
        logic test_en;
        logic test_mode;
        logic lbist_en;
        logic busy;
        logic done;
    } lbist_ctrl_t;

endpackage

// File: rtl/lbist_seed_rom.sv
// Combinational seed lookup over LBIST_SEEDS.
//   idx    in  IDX_W       seed index
//   seed_c out SEED_WIDTH  seed for idx (zero when idx is past the table)
module lbist_seed_rom
    import lbist_pkg::*;
#(
    parameter int unsigned SEED_WIDTH = 25,
    parameter int unsigned IDX_W      = 4
) (
    input  logic [IDX_W-1:0]      idx,
    output logic [SEED_WIDTH-1:0] seed_c
);

    localparam int unsigned ROM_IDX_W = $clog2(LBIST_SEED_NUM);

    logic [ROM_IDX_W-1:0] rom_idx;

    // Table lookup, guarded against indices beyond the table
    always_comb begin
        rom_idx = ROM_IDX_W'(idx);
        seed_c  = '0;
        if (32'(idx) < LBIST_SEED_NUM) begin
            seed_c = SEED_WIDTH'(LBIST_SEEDS[rom_idx]);
        end
    end

endmodule

// File: rtl/lbist_seq_ctrl.sv
// LBIST session sequencer: seeds the LFSR, alternates shift/capture,
// unloads the final response into the MISR and grades the signature.
//   CLK, RST   in  clock, synchronous active-high reset
//   START      in  session request, sampled in IDLE/DONE only
//   MISR_SIG   in  current MISR signature
//   LFSR_LOAD/LFSR_SEED/LFSR_EN   out  pattern generator controls
//   MISR_EN/MISR_CLR              out  compactor controls
//   TEST_EN/TEST_MODE/LBIST_EN    out  core test-mode controls
//   BUSY/DONE/GO_NOGO             out  session status and verdict
// All outputs are registered and decoded from the next state.
module lbist_seq_ctrl
    import lbist_pkg::*;
#(
    parameter int unsigned SEED_WIDTH        = 25,
    parameter int unsigned SEED_NUM          = 10,
    parameter int unsigned PATTERNS_PER_SEED = 200,
    parameter int unsigned CHAIN_LEN         = 24,
    parameter int unsigned MISR_SIZE         = 16,
    parameter logic [MISR_SIZE-1:0] MISR_GOLD = MISR_SIZE'(LBIST_MISR_GOLD)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [MISR_SIZE-1:0]  MISR_SIG,
    output logic                  LFSR_LOAD,
    output logic [SEED_WIDTH-1:0] LFSR_SEED,
    output logic                  LFSR_EN,
    output logic                  MISR_EN,
    output logic                  MISR_CLR,
    output logic                  TEST_EN,
    output logic                  TEST_MODE,
    output logic                  LBIST_EN,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  GO_NOGO
);

    localparam int unsigned SHIFT_W = (CHAIN_LEN > 1)         ? $clog2(CHAIN_LEN)         : 1;
    localparam int unsigned PAT_W   = (PATTERNS_PER_SEED > 1) ? $clog2(PATTERNS_PER_SEED) : 1;
    localparam int unsigned SEED_W  = (SEED_NUM > 1)          ? $clog2(SEED_NUM)          : 1;

    localparam logic [SHIFT_W-1:0]    SHIFT_LAST = SHIFT_W'(CHAIN_LEN - 1);
    localparam logic [PAT_W-1:0]      PAT_LAST   = PAT_W'(PATTERNS_PER_SEED - 1);
    localparam logic [SEED_W-1:0]     SEED_LAST  = SEED_W'(SEED_NUM - 1);
    localparam logic [SEED_WIDTH-1:0] SEED_RST   = SEED_WIDTH'(LBIST_SEEDS[0]);

    lbist_state_e          state_q, state_d;
    logic [SHIFT_W-1:0]    shift_cnt_q, shift_cnt_d;
    logic [PAT_W-1:0]      pat_cnt_q, pat_cnt_d;
    logic [SEED_W-1:0]     seed_idx_q, seed_idx_d;
    lbist_ctrl_t           ctrl_q, ctrl_d;
    logic                  go_nogo_q, go_nogo_d;
    logic [SEED_WIDTH-1:0] seed_q;
    logic [SEED_WIDTH-1:0] seed_nxt_c;

    // Seed for the next-state index, so LFSR_SEED is valid alongside LFSR_LOAD
    lbist_seed_rom #(
        .SEED_WIDTH (SEED_WIDTH),
        .IDX_W      (SEED_W)
    ) u_seed_rom (
        .idx    (seed_idx_d),
        .seed_c (seed_nxt_c)
    );

    // State, counters and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            shift_cnt_q <= '0;
            pat_cnt_q   <= '0;
            seed_idx_q  <= '0;
            ctrl_q      <= '0;
            go_nogo_q   <= 1'b0;
            seed_q      <= SEED_RST;
        end else begin
            state_q     <= state_d;
            shift_cnt_q <= shift_cnt_d;
            pat_cnt_q   <= pat_cnt_d;
            seed_idx_q  <= seed_idx_d;
            ctrl_q      <= ctrl_d;
            go_nogo_q   <= go_nogo_d;
            seed_q      <= seed_nxt_c;
        end
    end

    // Next state, counter updates and next-state output decode
    always_comb begin
        state_d     = state_q;
        shift_cnt_d = shift_cnt_q;
        pat_cnt_d   = pat_cnt_q;
        seed_idx_d  = seed_idx_q;
        ctrl_d      = '0;
        go_nogo_d   = go_nogo_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                seed_idx_d  = '0;
                pat_cnt_d   = '0;
                shift_cnt_d = '0;
                state_d     = ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    shift_cnt_d = '0;
                    state_d     = ST_CAPTURE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (pat_cnt_q != PAT_LAST) begin
                    pat_cnt_d = pat_cnt_q + PAT_W'(1);
                    state_d   = ST_SHIFT;
                end else begin
                    pat_cnt_d = '0;
                    if (seed_idx_q != SEED_LAST) begin
                        seed_idx_d = seed_idx_q + SEED_W'(1);
                        state_d    = ST_LOAD;
                    end else begin
                        state_d = ST_UNLOAD;
                    end
                end
            end
            ST_UNLOAD: begin
                if (shift_cnt_q == SHIFT_LAST) begin
                    shift_cnt_d = '0;
                    state_d     = ST_COMPARE;
                end else begin
                    shift_cnt_d = shift_cnt_q + SHIFT_W'(1);
                end
            end
            ST_COMPARE: begin
                // MISR_SIG already reflects the last unload shift here
                go_nogo_d = (MISR_SIG == MISR_GOLD);
                state_d   = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new session drops the previous verdict
        if (state_d == ST_INIT) begin
            go_nogo_d = 1'b0;
        end

        unique case (state_d)
            ST_INIT:             ctrl_d.misr_clr  = 1'b1;
            ST_LOAD:             ctrl_d.lfsr_load = 1'b1;
            ST_SHIFT, ST_UNLOAD: begin
                ctrl_d.test_en = 1'b1;
                ctrl_d.lfsr_en = 1'b1;
                ctrl_d.misr_en = 1'b1;
            end
            ST_DONE:             ctrl_d.done      = 1'b1;
            default:             ;
        endcase

        if ((state_d != ST_IDLE) && (state_d != ST_DONE)) begin
            ctrl_d.test_mode = 1'b1;
            ctrl_d.lbist_en  = 1'b1;
            ctrl_d.busy      = 1'b1;
        end
    end

    assign LFSR_LOAD = ctrl_q.lfsr_load;
    assign LFSR_SEED = seed_q;
    assign LFSR_EN   = ctrl_q.lfsr_en;
    assign MISR_EN   = ctrl_q.misr_en;
    assign MISR_CLR  = ctrl_q.misr_clr;
    assign TEST_EN   = ctrl_q.test_en;
    assign TEST_MODE = ctrl_q.test_mode;
    assign LBIST_EN  = ctrl_q.lbist_en;
    assign BUSY      = ctrl_q.busy;
    assign DONE      = ctrl_q.done;
    assign GO_NOGO   = go_nogo_q;

endmodule

// File: tb/tb_lbist_seq_ctrl.sv
// Self-checking bench for lbist_seq_ctrl with a small configuration.
// The reference model tracks only "cycles since START was accepted" and
// derives every output from the session schedule arithmetic.
module tb_lbist_seq_ctrl;
    import lbist_pkg::*;

    localparam int NS   = 2;
    localparam int P    = 3;
    localparam int CL   = 4;
    localparam int SL   = 1 + P * (CL + 1);       // cycles per seed
    localparam int SESS = 1 + NS * SL + CL + 1;   // START edge to DONE edge
    localparam logic [15:0] GOLD = 16'h68BF;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic [15:0] MISR_SIG = '0;
    logic        LFSR_LOAD, LFSR_EN, MISR_EN, MISR_CLR, TEST_EN;
    logic        TEST_MODE, LBIST_EN, BUSY, DONE, GO_NOGO;
    logic [24:0] LFSR_SEED;

    lbist_seq_ctrl #(
        .SEED_WIDTH        (25),
        .SEED_NUM          (NS),
        .PATTERNS_PER_SEED (P),
        .CHAIN_LEN         (CL),
        .MISR_SIZE         (16),
        .MISR_GOLD         (GOLD)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .START     (START),
        .MISR_SIG  (MISR_SIG),
        .LFSR_LOAD (LFSR_LOAD),
        .LFSR_SEED (LFSR_SEED),
        .LFSR_EN   (LFSR_EN),
        .MISR_EN   (MISR_EN),
        .MISR_CLR  (MISR_CLR),
        .TEST_EN   (TEST_EN),
        .TEST_MODE (TEST_MODE),
        .LBIST_EN  (LBIST_EN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .GO_NOGO   (GO_NOGO)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: session progress as a cycle offset
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_go     = 1'b0;
    int m_k      = 0;

    always @(posedge CLK) begin
        if (RST) begin
            m_active <= 1'b0; m_done <= 1'b0; m_go <= 1'b0; m_k <= 0;
        end else if (!m_active && START) begin
            m_active <= 1'b1; m_done <= 1'b0; m_go <= 1'b0; m_k <= 0;
        end else if (m_active) begin
            if (m_k + 1 == SESS) begin
                m_active <= 1'b0; m_done <= 1'b1; m_go <= (MISR_SIG == GOLD);
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    // {LOAD, LFSR_EN, MISR_EN, MISR_CLR, TEST_EN, TEST_MODE, LBIST_EN, BUSY, DONE, GO_NOGO}
    function automatic logic [9:0] exp_outs(bit act, bit dn, bit go, int k);
        logic [9:0] v;
        int r;
        v = '0;
        if (dn) begin
            v[1] = 1'b1;
            v[0] = go;
        end else if (act) begin
            v[4] = 1'b1; v[3] = 1'b1; v[2] = 1'b1;
            if (k == 0) begin
                v[6] = 1'b1;
            end else if (k <= NS * SL) begin
                r = (k - 1) % SL;
                if (r == 0) v[9] = 1'b1;
                else if (((r - 1) % (CL + 1)) < CL) begin
                    v[8] = 1'b1; v[7] = 1'b1; v[5] = 1'b1;
                end
            end else if (k <= NS * SL + CL) begin
                v[8] = 1'b1; v[7] = 1'b1; v[5] = 1'b1;
            end
        end
        return v;
    endfunction

    logic [9:0] act_vec, exp_vec;
    assign act_vec = {LFSR_LOAD, LFSR_EN, MISR_EN, MISR_CLR, TEST_EN,
                      TEST_MODE, LBIST_EN, BUSY, DONE, GO_NOGO};

    // Cycle-by-cycle compare against the model
    always @(negedge CLK) begin
        if (chk_en) begin
            exp_vec = exp_outs(m_active, m_done, m_go, m_k);
            check("outputs", 32'(act_vec), 32'(exp_vec));
            if (exp_vec[9]) begin
                check("lfsr_seed", 32'(LFSR_SEED), 32'(LBIST_SEEDS[4'((m_k - 1) / SL)]));
            end
        end
    end

    int s_loads, s_te, s_caps, s_clrs;

    // Runs one session from a START pulse; len = cycles to DONE, -2 if reset injected
    task automatic run_session(input logic [15:0] sig, input int pa, input int pb,
                               input int rst_at, input bit hold, output int len);
        int  c;
        bit  te_prev, fall_prev, stop;
        s_loads = 0; s_te = 0; s_caps = 0; s_clrs = 0;
        te_prev = 1'b0; fall_prev = 1'b0; stop = 1'b0;
        len = -1;
        MISR_SIG = 16'($urandom);
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        if (!hold) START = 1'b0;
        c = 0;
        while (!stop && c <= 100) begin
            if (LFSR_LOAD) s_loads++;
            if (TEST_EN)   s_te++;
            if (MISR_CLR)  s_clrs++;
            if (fall_prev && !DONE) s_caps++;
            fall_prev = te_prev && !TEST_EN;
            te_prev   = TEST_EN;
            if (DONE) begin
                len  = c;
                stop = 1'b1;
            end else if (c == rst_at) begin
                RST   = 1'b1;
                START = 1'b0;
                @(negedge CLK);
                check("rst_test_mode", 32'(TEST_MODE), 32'd0);
                check("rst_busy", 32'(BUSY), 32'd0);
                RST  = 1'b0;
                len  = -2;
                stop = 1'b1;
            end else begin
                if (c == pa || c == pb) START = 1'b1;
                else if (!hold)         START = 1'b0;
                if (c == 30) MISR_SIG = sig;
                @(negedge CLK);
                c++;
            end
        end
        if (len == -1) check("done_seen", 32'(DONE), 32'd1);
    endtask

    int len;
    int c2;
    logic [15:0] rsig;
    int rst_at, pa;

    initial begin
        // Reset then idle
        repeat (2) @(negedge CLK);
        chk_en = 1'b1;
        check("reset_seed", 32'(LFSR_SEED), 32'h1A2B3C5);
        check("reset_outs", 32'(act_vec), 32'd0);
        RST = 1'b0;
        repeat (20) @(negedge CLK);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_outs", 32'(act_vec), 32'd0);

        // Full session, signature match
        run_session(GOLD, -1, -1, -1, 1'b0, len);
        check("match_len", 32'(len), 32'd38);
        check("match_loads", 32'(s_loads), 32'd2);
        check("match_test_en", 32'(s_te), 32'd28);
        check("match_captures", 32'(s_caps), 32'd6);
        check("match_clr", 32'(s_clrs), 32'd1);
        check("match_go", 32'(GO_NOGO), 32'd1);
        repeat (3) @(negedge CLK);
        check("match_hold", 32'({DONE, GO_NOGO}), 32'd3);

        // Mismatch
        run_session(16'h0000, -1, -1, -1, 1'b0, len);
        check("mis_len", 32'(len), 32'd38);
        check("mis_done_go", 32'({DONE, GO_NOGO}), 32'd2);

        // Reset in the 3rd shift cycle of seed 1, then a clean session
        run_session(GOLD, -1, -1, 1 + SL + 3, 1'b0, len);
        check("abort_go", 32'(GO_NOGO), 32'd0);
        run_session(GOLD, -1, -1, -1, 1'b0, len);
        check("post_abort_len", 32'(len), 32'd38);

        // Extra START pulses mid-session are ignored
        run_session(GOLD, 5, 20, -1, 1'b0, len);
        check("extra_start_len", 32'(len), 32'd38);

        // START held through DONE restarts immediately
        run_session(GOLD, -1, -1, -1, 1'b1, len);
        check("hold_len", 32'(len), 32'd38);
        @(negedge CLK);
        check("restart_clr", 32'({MISR_CLR, BUSY, DONE}), 32'd6);
        START = 1'b0;
        c2 = 0;
        while (!DONE && c2 < 100) begin
            @(negedge CLK);
            c2++;
        end
        check("restart_len", 32'(c2), 32'd38);

        // Randomized sessions
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(0, 5)) @(negedge CLK);
            rsig   = ($urandom_range(0, 1) == 1) ? GOLD : 16'($urandom);
            rst_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 36)) : -1;
            pa     = int'($urandom_range(1, 37));
            run_session(rsig, pa, -1, rst_at, 1'b0, len);
            if (rst_at < 0) begin
                check("rand_len", 32'(len), 32'd38);
                check("rand_go", 32'(GO_NOGO), 32'(rsig == GOLD));
            end
        end

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
